// File: rtl/cordic_pkg.sv
// Shared definitions for the sequential CORDIC controller: state encoding,
// parameter defaults and the iteration index helper.
package cordic_pkg;

    localparam int ITER_DEFAULT = 16;
    localparam int W_DEFAULT    = 16;
    localparam int ADDR_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ITER    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } cordic_state_t;

    // Index of the final CORDIC iteration for a given iteration count.
    function automatic logic [ADDR_W-1:0] last_index(input int iter);
        return ADDR_W'(iter - 1);
    endfunction

endpackage

// File: rtl/cordic_iter_cnt.sv
// Iteration counter: counts up while enabled, saturates at the last index and
// flags it on tc so the sequencer never sees a wrapped address.
import cordic_pkg::*;

module cordic_iter_cnt #(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    output logic [ADDR_W-1:0] count,
    output logic              tc
);

    logic [ADDR_W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable && !tc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
    assign tc    = (count_reg == last_index(ITER));

endmodule

// File: rtl/cordic16_seq.sv
// Sequencer for an external iterative CORDIC datapath: accepts an angle, steps
// the datapath through ITER iterations, captures sin/cos and holds them until read.
import cordic_pkg::*;

module cordic16_seq #(
    parameter int ITER = ITER_DEFAULT,
    parameter int W    = W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic [W-1:0]      req_angle,
    output logic              req_ready,
    input  logic              abort,
    output logic [W-1:0]      endangle,
    output logic              load,
    output logic [ADDR_W-1:0] addr,
    input  logic [W-1:0]      cd_sin,
    input  logic [W-1:0]      cd_cos,
    output logic [W-1:0]      sin_out,
    output logic [W-1:0]      cos_out,
    output logic              valid,
    input  logic              ready,
    output logic              busy
);

    cordic_state_t state_reg;
    cordic_state_t state_next;

    logic [W-1:0]      endangle_reg;
    logic [W-1:0]      sin_reg;
    logic [W-1:0]      cos_reg;
    logic [ADDR_W-1:0] cnt_value;
    logic              cnt_tc;
    logic              cnt_clear;
    logic              cnt_enable;
    logic              accept;
    logic              capture;

    assign accept  = (state_reg == ST_IDLE) && req;
    assign capture = (state_reg == ST_CAPTURE) && !abort;

    // The counter only survives ITER and the CAPTURE cycle that follows it;
    // leaving CAPTURE or aborting returns the address to zero.
    assign cnt_clear  = (state_reg != ST_ITER) || abort;
    assign cnt_enable = (state_reg == ST_ITER);

    cordic_iter_cnt #(
        .ITER (ITER)
    ) u_iter_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (cnt_value),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Abort outranks every forward transition out of LOAD, ITER and CAPTURE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = abort ? ST_IDLE : ST_ITER;
            end
            ST_ITER: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (cnt_tc) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_next = abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_reg == ST_IDLE);
        busy      = (state_reg != ST_IDLE);
        load      = (state_reg == ST_LOAD);
        valid     = (state_reg == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            endangle_reg <= '0;
        end else if (accept) begin
            endangle_reg <= req_angle;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sin_reg <= '0;
            cos_reg <= '0;
        end else if (capture) begin
            sin_reg <= cd_sin;
            cos_reg <= cd_cos;
        end
    end

    assign endangle = endangle_reg;
    assign addr     = cnt_value;
    assign sin_out  = sin_reg;
    assign cos_out  = cos_reg;

endmodule

// File: tb/tb_cordic16_seq.sv
// Bench for cordic16_seq: directed scenarios plus random traffic, checked every
// cycle against a timeline model counting cycles since request acceptance.
module tb_cordic16_seq;

    localparam int ITER = 16;
    localparam int W    = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req = 1'b0;
    logic [W-1:0] req_angle = '0;
    logic         abort = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] cd_sin = '0;
    logic [W-1:0] cd_cos = '0;
    logic         req_ready;
    logic [W-1:0] endangle;
    logic         load;
    logic [3:0]   addr;
    logic [W-1:0] sin_out;
    logic [W-1:0] cos_out;
    logic         valid;
    logic         busy;

    cordic16_seq #(
        .ITER (ITER),
        .W    (W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_angle (req_angle),
        .req_ready (req_ready),
        .abort     (abort),
        .endangle  (endangle),
        .load      (load),
        .addr      (addr),
        .cd_sin    (cd_sin),
        .cd_cos    (cd_cos),
        .sin_out   (sin_out),
        .cos_out   (cos_out),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int txn_count = 0;

    // Model: ph = -1 when idle, otherwise edges since the acceptance edge.
    // ph 0 = load cycle, 1..ITER = iterations, ITER+1 = capture, beyond = results held.
    int           ph = -1;
    logic [W-1:0] m_end = '0;
    logic [W-1:0] m_sin = '0;
    logic [W-1:0] m_cos = '0;
    bit           addr_zero = 1'b1;
    bit           prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            ph = -1;
            m_end = '0;
            m_sin = '0;
            m_cos = '0;
            addr_zero = 1'b1;
        end else if (ph < 0) begin
            if (req) begin
                ph = 0;
                m_end = req_angle;
            end
        end else if (ph <= ITER + 1) begin
            if (abort) begin
                ph = -1;
                addr_zero = 1'b1;
            end else begin
                if (ph == ITER + 1) begin
                    m_sin = cd_sin;
                    m_cos = cd_cos;
                end
                ph++;
            end
        end else if (ready) begin
            ph = -1;
            addr_zero = 1'b0;
        end
    endtask

    task automatic compare_outputs();
        int exp_addr;
        check("req_ready", 32'(req_ready), 32'(ph < 0));
        check("busy", 32'(busy), 32'(ph >= 0));
        check("valid", 32'(valid), 32'(ph >= ITER + 2));
        check("load", 32'(load), 32'(ph == 0));
        check("endangle", 32'(endangle), 32'(m_end));
        check("sin_out", 32'(sin_out), 32'(m_sin));
        check("cos_out", 32'(cos_out), 32'(m_cos));
        check("addr_max", 32'(addr <= 4'(ITER - 1)), 32'd1);
        if (ph >= 0 && ph <= ITER + 1) begin
            exp_addr = (ph == 0) ? 0 : (ph <= ITER) ? ph - 1 : ITER - 1;
            check("addr", 32'(addr), 32'(exp_addr));
        end else if (ph < 0 && addr_zero) begin
            check("addr_idle", 32'(addr), 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_outputs();
        if (valid === 1'b1 && !prev_valid) begin
            txn_count++;
            $display("txn %0d: angle=%h sin=%h cos=%h", txn_count, endangle, sin_out, cos_out);
        end
        prev_valid = (valid === 1'b1);
        cd_sin = W'($urandom);
        cd_cos = W'($urandom);
    endtask

    task automatic accept(input logic [W-1:0] a);
        req = 1'b1;
        req_angle = a;
        step();
        req = 1'b0;
    endtask

    task automatic run_to_phase(input int target);
        for (int i = 0; i < 64 && ph != target; i++) begin
            step();
        end
        check("reach_phase", 32'(ph), 32'(target));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (valid !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        check("valid_timeout", 32'(valid), 32'd1);
    endtask

    initial begin
        int n;

        repeat (3) step();
        reset = 1'b0;
        step();

        // Basic operation and latency
        accept(16'h2000);
        wait_valid(n);
        check("latency", 32'(n), 32'(ITER + 2));
        repeat (5) step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        step();

        // Request during ITER must be ignored
        accept(16'h1000);
        repeat (4) step();
        req = 1'b1;
        req_angle = 16'h7FFF;
        repeat (3) step();
        check("ignored_angle", 32'(endangle), 32'h1000);
        req = 1'b0;
        run_to_phase(ITER + 2);
        ready = 1'b1;
        step();
        ready = 1'b0;

        // Abort at addr 7
        accept(W'($urandom));
        run_to_phase(8);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle", 32'(req_ready), 32'd1);
        repeat (20) step();

        // Abort in CAPTURE, then abort in DONE
        accept(W'($urandom));
        run_to_phase(ITER + 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (3) step();
        accept(W'($urandom));
        run_to_phase(ITER + 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_done_valid", 32'(valid), 32'd1);
        ready = 1'b1;
        step();
        ready = 1'b0;

        // Reset mid-ITER and in DONE, then a normal operation
        accept(W'($urandom));
        run_to_phase(11);
        reset = 1'b1;
        step();
        reset = 1'b0;
        accept(W'($urandom));
        run_to_phase(ITER + 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        accept(16'h2000);
        wait_valid(n);
        check("latency_after_reset", 32'(n), 32'(ITER + 2));
        ready = 1'b1;
        step();
        ready = 1'b0;

        // Random traffic
        repeat (1500) begin
            req       = ($urandom_range(0, 9) < 3);
            req_angle = W'($urandom);
            abort     = ($urandom_range(0, 99) < 3);
            ready     = ($urandom_range(0, 1) == 1);
            reset     = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        req = 1'b0;
        abort = 1'b0;
        ready = 1'b1;
        repeat (30) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
